// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ lanes.
// Defining ALU_ARB_STATS_EN adds the stat_ops/stat_stall counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module alu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [4*NUM_REQ-1:0]          req_opcode,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_b,
  output logic [3:0]                    alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_operand_a,
  output logic [DATA_WIDTH-1:0]         alu_operand_b,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_cmp_flag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_cmp_flag,
  output logic                          busy
`ifdef ALU_ARB_STATS_EN
  ,output logic [15:0]                  stat_ops,
  output logic [15:0]                   stat_stall
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] last_grant, grant_idx, winner, cand;
  logic found, accept;
  // Scan downward so the lane nearest after last_grant is the last one written.
  always_comb begin
    winner = '0;
    found = 1'b0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner = cand;
        found = 1'b1;
      end
    end
  end
  assign accept = (state == IDLE) && found;
  assign busy = state != IDLE;
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = RESP;
      default: state_nx = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_idx <= '0;
      alu_opcode <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_result <= '0;
      resp_cmp_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_opcode <= req_opcode[winner*4 +: 4];
        alu_operand_a <= req_operand_a[winner*DATA_WIDTH +: DATA_WIDTH];
        alu_operand_b <= req_operand_b[winner*DATA_WIDTH +: DATA_WIDTH];
        grant_idx <= winner;
      end
      if (state == ISSUE) begin
        resp_result <= alu_result;
        resp_cmp_flag <= alu_cmp_flag;
        resp_id <= grant_idx;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        last_grant <= resp_id;
      end
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_stall <= '0;
    end else begin
      if (state == RESP && resp_ready) stat_ops <= stat_ops + 16'd1;
      if (|req_valid && !accept) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random lanes/backpressure/resets against a transaction-level model.
module tb_alu_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready;
  logic [4*N-1:0] req_opcode;
  logic [W*N-1:0] req_operand_a, req_operand_b;
  logic [3:0] alu_opcode;
  logic [W-1:0] alu_operand_a, alu_operand_b, alu_result, resp_result;
  logic alu_cmp_flag, resp_valid, resp_ready, resp_cmp_flag, busy;
  logic [1:0] resp_id;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops, stat_stall, m_ops, m_stall;
`endif
  int checks = 0;
  int errors = 0;
  int m_phase, m_last, m_lane, m_id;
  logic m_valid, m_flag;
  logic [3:0] m_op;
  logic [W-1:0] m_a, m_b, m_res;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_cmp_flag(alu_cmp_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_cmp_flag(resp_cmp_flag), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0, 4'd4: return {1'b0, a + b};
      4'd1:       return {1'b0, a - b};
      4'd2:       return {1'b0, W'(a * b)};
      4'd3:       return {a < b, {W{1'b0}}};
      default:    return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_cmp_flag, alu_result} = alu_f(alu_opcode, alu_operand_a, alu_operand_b);

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_phase = 0; m_last = N - 1; m_lane = 0; m_id = 0;
    m_valid = 1'b0; m_flag = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_res = '0;
`ifdef ALU_ARB_STATS_EN
    m_ops = '0; m_stall = '0;
`endif
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_opcode = '0; req_operand_a = '0; req_operand_b = '0; resp_ready = 1'b1;
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[l] = 1'b1;
    req_opcode[4*l +: 4] = op;
    req_operand_a[W*l +: W] = a;
    req_operand_b[W*l +: W] = b;
  endtask

  // Called in the low clock phase with inputs already applied; checks, then models one edge.
  task automatic tick();
    int w;
    #1;
    w = pick(m_last, req_valid);
    check("req_ready", 64'(req_ready), (m_phase == 0 && w >= 0) ? (64'd1 << w) : 64'd0);
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("resp_valid", 64'(resp_valid), 64'(m_valid));
    check("resp_id", 64'(resp_id), 64'(m_id));
    check("resp_result", 64'(resp_result), 64'(m_res));
    check("resp_cmp_flag", 64'(resp_cmp_flag), 64'(m_flag));
    check("alu_opcode", 64'(alu_opcode), 64'(m_op));
    check("alu_operand_a", 64'(alu_operand_a), 64'(m_a));
    check("alu_operand_b", 64'(alu_operand_b), 64'(m_b));
`ifdef ALU_ARB_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(m_ops));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    @(posedge clk);
    if (!rst_n) reset_model();
    else begin
`ifdef ALU_ARB_STATS_EN
      if (m_phase == 2 && resp_ready) m_ops++;
      if (|req_valid && !(m_phase == 0 && w >= 0)) m_stall++;
`endif
      case (m_phase)
        0: if (w >= 0) begin
          m_lane = w;
          m_op = req_opcode[4*w +: 4];
          m_a = req_operand_a[W*w +: W];
          m_b = req_operand_b[W*w +: W];
          m_phase = 1;
        end
        1: begin
          {m_flag, m_res} = alu_f(m_op, m_a, m_b);
          m_id = m_lane;
          m_valid = 1'b1;
          m_phase = 2;
        end
        default: if (resp_ready) begin
          m_valid = 1'b0;
          m_last = m_id;
          m_phase = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    set_lane(1, 4'd0, 16'd7, 16'd5);
    #1 check("tp1_ready", 64'(req_ready), 64'b0010);
    tick();
    clear_inputs();
    #1 check("tp1_alu_a", 64'(alu_operand_a), 64'd7);
    tick();
    #1 check("tp1_valid", 64'(resp_valid), 64'd1);
    check("tp1_result", 64'(resp_result), 64'd12);
    check("tp1_id", 64'(resp_id), 64'd1);
    tick();
    set_lane(0, 4'd2, 16'd6, 16'd3);
    tick();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("tp4_valid", 64'(resp_valid), 64'd0);
    check("tp4_busy", 64'(busy), 64'd0);
    set_lane(2, 4'd4, 16'd10, 16'd15);
    tick();
    clear_inputs();
    tick();
    #1 check("tp4_result", 64'(resp_result), 64'd25);
    check("tp4_id", 64'(resp_id), 64'd2);
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 63) != 0;
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
      req_opcode = 16'($urandom);
      req_operand_a = {$urandom, $urandom};
      req_operand_b = {$urandom, $urandom};
      resp_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
